// File: rtl/stream_averaging_filter.sv
// ---------------------------------------------------------------------------
// stream_averaging_filter
//
// Streaming raster-scan R_K x C_K box (averaging) filter over an R_I x C_I
// frame. Pixels arrive one per valid/ready handshake in row-major order. A
// shift register spanning (R_K-1) full lines plus C_K pixels provides the
// window. Window taps outside the frame are zero-padded. The divisor is
// always R_K*C_K, including at the borders.
//
// After the last pixel of a frame, the block runs LAG internal zero-data
// steps (FLUSH) so that the trailing centres still come out. Every output
// pixel then passes through DEPTH registered adder-tree stages and one
// divide register.
//
// Optional feature macro: AVG_ROUND_EN
//   defined   : round-to-nearest division, saturating at 2**W_I-1
//   undefined : truncating division (default)
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous reset, active-high
//   cen      clock enable; low freezes all state
//   s_valid  input pixel valid
//   s_ready  block accepts a pixel this cycle
//   s_data   input pixel, row-major raster order
//   m_valid  output pixel valid
//   m_ready  downstream accepts output
//   m_data   filtered pixel
//   m_last   high with the final pixel of a frame
//   busy     frame in progress or pipeline still holds data
// ---------------------------------------------------------------------------
module stream_averaging_filter #(
    parameter int R_I = 5,
    parameter int C_I = 5,
    parameter int W_I = 8,
    parameter int R_K = 3,
    parameter int C_K = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W_I-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W_I-1:0] m_data,
    output logic           m_last,
    output logic           busy
);

    localparam int HR    = (R_K - 1) / 2;
    localparam int HC    = (C_K - 1) / 2;
    localparam int KN    = R_K * C_K;
    localparam int DEPTH = $clog2(KN);
    localparam int W_F   = W_I + DEPTH;
    localparam int LAG   = HR * C_I + HC;
    localparam int N     = R_I * C_I;
    localparam int TOT   = N + LAG;
    localparam int L     = (R_K - 1) * C_I + C_K;
    localparam int WL    = (L > 1) ? L - 1 : 1;
    localparam int NL    = 2 ** DEPTH;
    localparam int SW    = $clog2(TOT + 1);
    localparam int RW    = $clog2(R_I + 1);
    localparam int CW    = $clog2(C_I + 1);

    localparam logic [SW-1:0]  LAG_S = SW'(LAG);
    localparam logic [SW-1:0]  N_S   = SW'(N);
    localparam logic [SW-1:0]  TOT_S = SW'(TOT);
    localparam logic [RW-1:0]  RLAST = RW'(R_I - 1);
    localparam logic [CW-1:0]  CLAST = CW'(C_I - 1);
    localparam logic [W_F-1:0] KN_F  = W_F'(KN);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state;
    logic [SW-1:0]   step_idx;
    logic [SW-1:0]   step_next;
    logic [RW-1:0]   c_row;
    logic [CW-1:0]   c_col;
    logic [W_I-1:0]  win    [WL];
    logic [W_I-1:0]  newsr  [L];
    logic [W_F-1:0]  leaves [NL];
    logic [W_F-1:0]  sums   [DEPTH][NL];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] lastp;
    logic [W_F-1:0]  total;
    logic [W_I-1:0]  div_out;
    logic [W_I-1:0]  sample_in;
    logic            adv;
    logic            accept;
    logic            do_step;
    logic            produce;
    logic            centre_last;

    // The whole block advances only when enabled and the output register is
    // free (or being drained this cycle).
    assign adv         = cen & ~(m_valid & ~m_ready);
    assign s_ready     = adv & (state != FLUSH);
    assign accept      = s_valid & s_ready;
    assign do_step     = accept | (adv & (state == FLUSH));
    assign produce     = do_step & (step_idx >= LAG_S);
    assign step_next   = step_idx + SW'(1);
    assign centre_last = (c_row == RLAST) && (c_col == CLAST);
    assign sample_in   = (state == FLUSH) ? '0 : s_data;
    assign busy        = (state != IDLE) | (|vld) | m_valid;
    assign total       = sums[DEPTH-1][0];

    // The view of the shift register as it will be after this step: element 0
    // is the incoming sample, element k the sample k steps older.
    always_comb begin
        newsr[0] = sample_in;
        for (int k = 1; k < L; k++) begin
            newsr[k] = win[k-1];
        end
    end

    // Map the window onto the adder-tree leaves. A tap at window offset
    // (i, j) from the newest sample sits at frame position
    // (c_row + HR - i, c_col + HC - j). Taps outside the frame are zeroed, so
    // stale data from an earlier frame and wrap-around from the
    // neighbouring row are both excluded.
    always_comb begin
        int tr;
        int tc;
        tr = 0;
        tc = 0;
        for (int e = 0; e < NL; e++) begin
            leaves[e] = '0;
        end
        for (int i = 0; i < R_K; i++) begin
            for (int j = 0; j < C_K; j++) begin
                tr = int'(c_row) + HR - i;
                tc = int'(c_col) + HC - j;
                if (tr >= 0 && tr < R_I && tc >= 0 && tc < C_I) begin
                    leaves[i*C_K+j] = W_F'(newsr[i*C_I+j]);
                end
            end
        end
    end

    // Divide the final tree sum by the full kernel area.
`ifdef AVG_ROUND_EN
    logic [W_F:0] biased;
    logic [W_F:0] quot;
    always_comb begin
        biased = {1'b0, total} + (W_F+1)'(KN / 2);
        quot   = biased / (W_F+1)'(KN);
        if (quot > (W_F+1)'((2 ** W_I) - 1)) begin
            div_out = '1;
        end else begin
            div_out = quot[W_I-1:0];
        end
    end
`else
    always_comb begin
        div_out = W_I'(total / KN_F);
    end
`endif

    // Sequencer, window shift register, adder-tree pipeline and output
    // register. All of these move together on adv, so backpressure stalls
    // the whole pipeline without dropping or duplicating pixels. step_idx
    // counts input and flush steps within a frame. The centre counters
    // follow LAG steps behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_idx <= '0;
            c_row    <= '0;
            c_col    <= '0;
            vld      <= '0;
            lastp    <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
        end else if (adv) begin
            if (do_step) begin
                for (int k = 0; k < L - 1; k++) begin
                    win[k] <= newsr[k];
                end
                if (step_next == TOT_S) begin
                    state    <= IDLE;
                    step_idx <= '0;
                end else begin
                    step_idx <= step_next;
                    if (step_next >= N_S) begin
                        state <= FLUSH;
                    end else if (step_next >= LAG_S) begin
                        state <= RUN;
                    end else begin
                        state <= FILL;
                    end
                end
            end

            if (produce) begin
                if (c_col == CLAST) begin
                    c_col <= '0;
                    c_row <= (c_row == RLAST) ? '0 : c_row + RW'(1);
                end else begin
                    c_col <= c_col + CW'(1);
                end
            end

            for (int e = 0; e < NL / 2; e++) begin
                sums[0][e] <= leaves[2*e] + leaves[2*e+1];
            end
            for (int d = 1; d < DEPTH; d++) begin
                for (int e = 0; e < (NL >> (d + 1)); e++) begin
                    sums[d][e] <= sums[d-1][2*e] + sums[d-1][2*e+1];
                end
            end

            vld[0]   <= produce;
            lastp[0] <= produce & centre_last;
            for (int d = 1; d < DEPTH; d++) begin
                vld[d]   <= vld[d-1];
                lastp[d] <= lastp[d-1];
            end

            m_valid <= vld[DEPTH-1];
            m_last  <= lastp[DEPTH-1];
            m_data  <= div_out;
        end
    end

endmodule
